// File: rtl/mano_io_port.sv
// Device-side responder for the Mano programmed-I/O handshake: buffered INPR/FGI input
// channel, OUTR/FGO output channel with device busy time, and the I/O interrupt request.
//   state   | meaning
//   TX_IDLE | fgo=1, waiting for the core's OUT
//   TX_SEND | byte presented on tx_data/tx_valid until the sink takes it
//   TX_BUSY | device busy countdown before fgo re-asserts
module mano_io_port #(
  parameter int DATAW    = 8,
  parameter int FIFO_AW  = 2,
  parameter int TX_DELAY = 2
) (
  input  logic               mclk,
  input  logic               mrst,
  input  logic               rx_valid,
  input  logic [DATAW-1:0]   rx_data,
  output logic               rx_ready,
  output logic [DATAW-1:0]   inpr,
  output logic               fgi,
  input  logic               core_inp,
  input  logic [DATAW-1:0]   outr_in,
  input  logic               core_out,
  output logic               fgo,
  input  logic               ien,
  output logic               irq,
  output logic               tx_valid,
  output logic [DATAW-1:0]   tx_data,
  input  logic               tx_ready,
  output logic [FIFO_AW:0]   rx_count,
  output logic               err_inp,
  output logic               err_out
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = (TX_DELAY > 0) ? $clog2(TX_DELAY + 1) : 1;

  typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_BUSY} tx_state_e;

  logic [DATAW-1:0]   mem_q [DEPTH];
  logic [DATAW-1:0]   mem_d [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic [DATAW-1:0]   inpr_q, inpr_d;
  logic               fgi_q, fgi_d;
  logic               err_inp_q, err_inp_d;
  tx_state_e          state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [DATAW-1:0]   tx_data_q, tx_data_d;
  logic               err_out_q, err_out_d;
  logic               push, pop;

  assign rx_ready = (count_q != (FIFO_AW+1)'(DEPTH));
  assign push     = rx_valid & rx_ready;
  // No bypass: only bytes already in the FIFO before this edge can move to inpr.
  assign pop      = ~fgi_q & ~core_inp & (count_q != '0);

  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    inpr_d    = inpr_q;
    fgi_d     = fgi_q;
    err_inp_d = err_inp_q;
    if (push) begin
      mem_d[wr_ptr_q] = rx_data;
      wr_ptr_d        = wr_ptr_q + FIFO_AW'(1);
    end
    if (pop) begin
      inpr_d   = mem_q[rd_ptr_q];
      fgi_d    = 1'b1;
      rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
    end
    if (push && !pop)      count_d = count_q + (FIFO_AW+1)'(1);
    else if (!push && pop) count_d = count_q - (FIFO_AW+1)'(1);
    if (core_inp) begin
      if (fgi_q) fgi_d     = 1'b0;
      else       err_inp_d = 1'b1;
    end
  end

  always_ff @(posedge mclk) begin
    if (mrst) begin
      mem_q     <= '{default: '0};
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      inpr_q    <= '0;
      fgi_q     <= 1'b0;
      err_inp_q <= 1'b0;
      state_q   <= TX_IDLE;
      cnt_q     <= '0;
      tx_data_q <= '0;
      err_out_q <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      inpr_q    <= inpr_d;
      fgi_q     <= fgi_d;
      err_inp_q <= err_inp_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tx_data_q <= tx_data_d;
      err_out_q <= err_out_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tx_data_d = tx_data_q;
    err_out_d = err_out_q;
    if (core_out && state_q != TX_IDLE) err_out_d = 1'b1;
    case (state_q)
      TX_IDLE: begin
        if (core_out) begin
          tx_data_d = outr_in;
          state_d   = TX_SEND;
        end
      end
      TX_SEND: begin
        if (tx_ready) begin
          if (TX_DELAY == 0) begin
            state_d = TX_IDLE;
          end else begin
            state_d = TX_BUSY;
            cnt_d   = CW'(TX_DELAY);
          end
        end
      end
      TX_BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = TX_IDLE;
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    fgo      = (state_q == TX_IDLE);
    tx_valid = (state_q == TX_SEND);
  end

  assign inpr     = inpr_q;
  assign fgi      = fgi_q;
  assign tx_data  = tx_data_q;
  assign rx_count = count_q;
  assign err_inp  = err_inp_q;
  assign err_out  = err_out_q;
  assign irq      = ien & (fgi_q | fgo);

endmodule
